bcd_tick_counter: RTL and testbench
===================================

# bcd_tick_counter

Downstream consumer of the divided square wave produced by the week-12 modulo divider. Detects each rising edge of the divided signal in the system clock domain and uses it as a count enable for a two-digit BCD up/down counter with programmable modulus, wrap pulse and synchronous clear. Typical use is a seconds/minutes display stage feeding the seven-segment driver.

## Interface
- MOD, default 60: counter modulus. Legal range 2..100. Count sequence is 0..MOD-1 in BCD.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- div_in  input  1  divided square wave from the divider; synchronous to clk.
- enable  input  1  count enable; ticks are ignored while low.
- up  input  1  direction, 1 = increment, 0 = decrement; sampled on the tick cycle.
- clear  input  1  synchronous clear to 00.
- ones  output  4  BCD ones digit, always 0..9.
- tens  output  4  BCD tens digit, 0..(MOD-1)/10.
- tick  output  1  registered one-cycle pulse marking each detected rising edge of div_in.
- wrap  output  1  registered one-cycle pulse when the count wraps (either direction).

## Operation
- Edge detector: register div_prev <= div_in every cycle. Internal rise = div_in & ~div_prev.
- div_prev resets to 1, so div_in already high at reset release yields no tick.
- Counter state: ones, tens registers, reset value 0/0. Terminal value T = MOD-1, T_tens = T/10, T_ones = T%10.
- Priority per edge: reset > clear > (rise & enable) > hold.
- clear: ones=0, tens=0, wrap=0. tick still reflects rise (edge detection is unaffected by clear and enable).
- Count up on rise & enable & up:
  - {tens,ones} == {T_tens,T_ones}: go to 00, wrap=1.
  - else ones == 9: ones=0, tens=tens+1.
  - else ones=ones+1.
- Count down on rise & enable & ~up:
  - {tens,ones} == 00: go to {T_tens,T_ones}, wrap=1.
  - else ones == 0: ones=9, tens=tens-1.
  - else ones=ones-1.
- No tick while enable low: count holds, wrap=0, tick still pulses.
- tick and wrap are 0 in every cycle not listed above; never high two consecutive cycles (div_in rises at most every other cycle).
- Digits outside legal BCD never produced; no illegal-state recovery required beyond reset.

## Timing
- Reset: ones=0, tens=0, tick=0, wrap=0, div_prev=1, asserted asynchronously, held until reset falls.
- Latency: div_in sampled high at edge N (low at N-1) -> at edge N: tick=1, count updated, wrap=1 if wrapping. All visible in the cycle after edge N; one clock of latency from div_in rise.
- wrap coincides with tick in the same cycle as the 00 (up) or T (down) value appears.
- clear asserted on a rise cycle: count goes to 00, tick=1, wrap=0.
- up changing between ticks has no effect until the next tick.
- Reset mid-count: outputs zero asynchronously; first tick after release requires a fresh low-to-high on div_in.

## Test plan
- Reset/edge: hold reset with div_in=1, release -> no tick on following cycles; first rise after div_in goes low produces tick=1 for exactly one cycle, count 00->01.
- Up with divider: MOD=60, div_in from modulo divider (rise every 12 clk), enable=1, up=1 -> 60 ticks, 59->00 with wrap=1 same cycle as 00, tens increments at 09->10, 19->20 etc.
- Down: MOD=60, preload by counting up to 10, then up=0 -> 10->09 (ones 0->9, tens 1->0); continue to 00 then next tick -> 59 with wrap=1.
- Odd modulus: MOD=7, up -> 0..6 then 00 with wrap; down from 00 -> 06 with wrap; tens stays 0 throughout.
- Enable/clear: enable=0 for 3 ticks -> count holds, tick pulses, wrap=0; clear on a rise cycle at 37 -> 00, tick=1, wrap=0.
- Async reset mid-count at 42 between clock edges -> ones/tens/tick/wrap 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter
//   Two-digit BCD up/down counter with programmable modulus (MOD, 2..100).
//   Each rising edge of div_in (a divided square wave synchronous to clk) is
//   one count event when enable is high. Count sequence is 0..MOD-1 in BCD.
//
// Ports
//   clk     : system clock, all state on rising edge
//   reset   : asynchronous active-high reset
//   div_in  : divided square wave, synchronous to clk
//   enable  : count enable; rises are ignored while low
//   up      : direction, 1 = increment, 0 = decrement (sampled on rise)
//   clear   : synchronous clear to 00 (wins over counting)
//   ones    : BCD ones digit
//   tens    : BCD tens digit
//   tick    : registered one-cycle pulse per detected rise of div_in
//   wrap    : registered one-cycle pulse when the count wraps
module bcd_tick_counter #(
    parameter int unsigned MOD = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       div_in,
    input  logic       enable,
    input  logic       up,
    input  logic       clear,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tick,
    output logic       wrap
);

    localparam int unsigned TERM   = MOD - 1;
    localparam logic [3:0]  T_TENS = 4'(TERM / 10);
    localparam logic [3:0]  T_ONES = 4'(TERM % 10);

    logic       div_prev;
    logic       rise_c;
    logic [3:0] ones_nxt;
    logic [3:0] tens_nxt;
    logic       wrap_nxt;

    // div_prev resets high so a div_in already high at release is not a rise
    assign rise_c = div_in & ~div_prev;

    // Next count: clear > (rise & enable) > hold
    always_comb begin
        ones_nxt = ones;
        tens_nxt = tens;
        wrap_nxt = 1'b0;
        if (clear) begin
            ones_nxt = 4'd0;
            tens_nxt = 4'd0;
        end else if (rise_c && enable) begin
            if (up) begin
                if (tens == T_TENS && ones == T_ONES) begin
                    ones_nxt = 4'd0;
                    tens_nxt = 4'd0;
                    wrap_nxt = 1'b1;
                end else if (ones == 4'd9) begin
                    ones_nxt = 4'd0;
                    tens_nxt = tens + 4'd1;
                end else begin
                    ones_nxt = ones + 4'd1;
                end
            end else begin
                if (tens == 4'd0 && ones == 4'd0) begin
                    ones_nxt = T_ONES;
                    tens_nxt = T_TENS;
                    wrap_nxt = 1'b1;
                end else if (ones == 4'd0) begin
                    ones_nxt = 4'd9;
                    tens_nxt = tens - 4'd1;
                end else begin
                    ones_nxt = ones - 4'd1;
                end
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_prev <= 1'b1;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            ones     <= 4'd0;
            tens     <= 4'd0;
        end else begin
            div_prev <= div_in;
            tick     <= rise_c;
            wrap     <= wrap_nxt;
            ones     <= ones_nxt;
            tens     <= tens_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Testbench for bcd_tick_counter: MOD=60 and MOD=7 instances share stimulus.
module tb_bcd_tick_counter;

    logic       clk;
    logic       reset;
    logic       div_in;
    logic       enable;
    logic       up;
    logic       clear;
    logic [3:0] ones60, tens60, ones7, tens7;
    logic       tick60, wrap60, tick7, wrap7;

    int checks;
    int errors;

    bcd_tick_counter #(.MOD(60)) dut60 (
        .clk(clk), .reset(reset), .div_in(div_in), .enable(enable), .up(up),
        .clear(clear), .ones(ones60), .tens(tens60), .tick(tick60), .wrap(wrap60)
    );

    bcd_tick_counter #(.MOD(7)) dut7 (
        .clk(clk), .reset(reset), .div_in(div_in), .enable(enable), .up(up),
        .clear(clear), .ones(ones7), .tens(tens7), .tick(tick7), .wrap(wrap7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int div;
        int en;
        int dir;
        int clr;
        int ones;
        int tens;
        int ones_m7;
        int tck;
        int wrp;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs mid-cycle, then sample 1 time unit after the next rising edge
    task automatic step(input int d, input int e, input int u, input int c);
        @(negedge clk);
        div_in = (d != 0);
        enable = (e != 0);
        up     = (u != 0);
        clear  = (c != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic rise(input int e, input int u);
        step(0, e, u, 0);
        step(1, e, u, 0);
    endtask

    task automatic chk60(input string name, input int val, input int tk, input int wr);
        chk({name, "_ones"}, int'(ones60), val % 10);
        chk({name, "_tens"}, int'(tens60), val / 10);
        chk({name, "_tick"}, int'(tick60), tk);
        chk({name, "_wrap"}, int'(wrap60), wr);
    endtask

    initial begin
        int v;
        checks = 0;
        errors = 0;

        // {div, en, up, clr, ones60, tens60, ones7, tick, wrap}
        vecs[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 1, 1, 0, 1, 0, 1, 1, 0};
        vecs[4]  = '{1, 1, 1, 0, 1, 0, 1, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 1, 0, 1, 0, 0};
        vecs[6]  = '{1, 0, 1, 0, 1, 0, 1, 1, 0};
        vecs[7]  = '{0, 1, 0, 0, 1, 0, 1, 0, 0};
        vecs[8]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 1, 0, 0, 9, 5, 6, 1, 1};
        vecs[11] = '{0, 1, 1, 0, 9, 5, 6, 0, 0};
        vecs[12] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        vecs[13] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{1, 1, 1, 0, 1, 0, 1, 1, 0};
        vecs[15] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
        vecs[16] = '{1, 1, 1, 0, 1, 0, 1, 1, 0};

        // Reset held with div_in high
        reset = 1'b1; div_in = 1'b1; enable = 1'b1; up = 1'b1; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk60("reset", 0, 0, 0);
        chk("reset_m7_tick", int'(tick7), 0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors
        foreach (vecs[i]) begin
            step(vecs[i].div, vecs[i].en, vecs[i].dir, vecs[i].clr);
            chk($sformatf("vec%0d_ones", i), int'(ones60), vecs[i].ones);
            chk($sformatf("vec%0d_tens", i), int'(tens60), vecs[i].tens);
            chk($sformatf("vec%0d_tick", i), int'(tick60), vecs[i].tck);
            chk($sformatf("vec%0d_wrap", i), int'(wrap60), vecs[i].wrp);
            chk($sformatf("vec%0d_m7_ones", i), int'(ones7), vecs[i].ones_m7);
            chk($sformatf("vec%0d_m7_tens", i), int'(tens7), 0);
            chk($sformatf("vec%0d_m7_tick", i), int'(tick7), vecs[i].tck);
            chk($sformatf("vec%0d_m7_wrap", i), int'(wrap7), vecs[i].wrp);
        end

        // Full up run, divider period 12 clocks (6 low, 6 high)
        step(0, 1, 1, 1);
        for (int k = 1; k <= 60; k++) begin
            repeat (6) step(0, 1, 1, 0);
            step(1, 1, 1, 0);
            chk60($sformatf("up%0d", k), k % 60, 1, (k == 60) ? 1 : 0);
            chk($sformatf("up%0d_m7_ones", k), int'(ones7), k % 7);
            chk($sformatf("up%0d_m7_tens", k), int'(tens7), 0);
            chk($sformatf("up%0d_m7_wrap", k), int'(wrap7), (k % 7 == 0) ? 1 : 0);
            step(1, 1, 1, 0);
            chk($sformatf("up%0d_tick_once", k), int'(tick60), 0);
            chk($sformatf("up%0d_wrap_once", k), int'(wrap60), 0);
            repeat (4) step(1, 1, 1, 0);
        end

        // Down from 10 through 00 to 59
        step(0, 1, 1, 1);
        repeat (10) rise(1, 1);
        chk60("preload10", 10, 1, 0);
        for (int k = 1; k <= 11; k++) begin
            rise(1, 0);
            v = 10 - k;
            if (v < 0) v += 60;
            chk60($sformatf("down%0d", k), v, 1, (k == 11) ? 1 : 0);
        end

        // Enable low holds, clear on a rise cycle
        step(0, 1, 1, 1);
        repeat (37) rise(1, 1);
        chk60("at37", 37, 1, 0);
        for (int k = 0; k < 3; k++) begin
            rise(0, 1);
            chk60($sformatf("hold%0d", k), 37, 1, 0);
        end
        step(0, 1, 1, 0);
        step(1, 1, 1, 1);
        chk60("clear_on_rise", 0, 1, 0);

        // Asynchronous reset between clock edges at 42
        step(0, 1, 1, 1);
        repeat (42) rise(1, 1);
        chk60("at42", 42, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk60("async_reset", 0, 0, 0);
        chk("async_reset_m7_ones", int'(ones7), 0);
        @(negedge clk);
        div_in = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk60("post_reset_hi", 0, 0, 0);
        step(1, 1, 1, 0);
        chk60("post_reset_hi2", 0, 0, 0);
        rise(1, 1);
        chk60("post_reset_rise", 1, 1, 0);
        step(0, 1, 1, 0);
        chk60("post_reset_after", 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
